alu_operand_stage: RTL and testbench

//  ID/EX pipeline stage that resolves and registers ALU operands (A, B, ALUFun) for the

---
 rtl/alu_operand_stage.sv | 151 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : ID/EX pipeline stage. Resolves ALU operands A/B at capture time
//            (EX/MEM and MEM/WB forwarding, immediate select), registers them
//            with the ALU function code, and stalls decode on load-use hazards.
//            valid/ready handshake on both sides.
// Ports    : clk, reset (sync, active-high), flush
//            upstream   : in_valid/in_ready, in_rs, in_rt, in_rs_data,
//                         in_rt_data, in_imm, in_use_imm, in_alufun, in_rd,
//                         in_is_load
//            forwarding : exm_we, exm_rd, exm_data, exm_is_load,
//                         wb_we, wb_rd, wb_data
//            downstream : out_valid/out_ready, A, B, ALUFun, out_rd,
//                         out_is_load
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int FW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [FW-1:0] in_alufun,
  input  logic [RW-1:0] in_rd,
  input  logic          in_is_load,
  input  logic          exm_we,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          exm_is_load,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [FW-1:0] ALUFun,
  output logic [RW-1:0] out_rd,
  output logic          out_is_load
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_hazard;
  logic          w_capture;
  logic [DW-1:0] w_rs_val;
  logic [DW-1:0] w_rt_val;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [FW-1:0] r_alufun;
  logic [RW-1:0] r_rd;
  logic          r_is_load;

  // Bypass network. A load in EX/MEM has no data yet, so it is never a
  // forwarding source; that case is covered by the hazard stall instead.
  function automatic logic [DW-1:0] resolve(
    input logic [RW-1:0] r,
    input logic [DW-1:0] rf_data,
    input logic          f_exm_we,
    input logic          f_exm_is_load,
    input logic [RW-1:0] f_exm_rd,
    input logic [DW-1:0] f_exm_data,
    input logic          f_wb_we,
    input logic [RW-1:0] f_wb_rd,
    input logic [DW-1:0] f_wb_data
  );
    logic [DW-1:0] v;
    if (r == '0)
      v = '0;
    else if (f_exm_we && !f_exm_is_load && (f_exm_rd == r))
      v = f_exm_data;
    else if (f_wb_we && (f_wb_rd == r))
      v = f_wb_data;
    else
      v = rf_data;
    return v;
  endfunction

  // rt only matters for the hazard when B actually comes from the register.
  assign w_hazard = exm_we && exm_is_load && (exm_rd != '0) &&
                    ((exm_rd == in_rs) || (!in_use_imm && (exm_rd == in_rt)));

  assign out_valid = (r_state == FULL);
  assign in_ready  = !flush && !w_hazard && (!out_valid || out_ready);
  assign w_capture = in_valid && in_ready;

  assign w_rs_val = resolve(in_rs, in_rs_data, exm_we, exm_is_load, exm_rd,
                            exm_data, wb_we, wb_rd, wb_data);
  assign w_rt_val = resolve(in_rt, in_rt_data, exm_we, exm_is_load, exm_rd,
                            exm_data, wb_we, wb_rd, wb_data);

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= EMPTY;
    else
      r_state <= w_state_next;
  end

  // in_ready already folds in flush, so a flushed cycle never captures.
  always_comb begin
    w_state_next = r_state;
    if (flush)
      w_state_next = EMPTY;
    else if (w_capture)
      w_state_next = FULL;
    else if ((r_state == FULL) && out_ready)
      w_state_next = EMPTY;
  end

  // Payload only moves on capture, so a stalled entry stays frozen and
  // out_ready has no path into A/B/ALUFun beyond the registered enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_alufun  <= '0;
      r_rd      <= '0;
      r_is_load <= 1'b0;
    end else if (w_capture) begin
      r_a       <= w_rs_val;
      r_b       <= in_use_imm ? in_imm : w_rt_val;
      r_alufun  <= in_alufun;
      r_rd      <= in_rd;
      r_is_load <= in_is_load;
    end
  end

  assign A           = r_a;
  assign B           = r_b;
  assign ALUFun      = r_alufun;
  assign out_rd      = r_rd;
  assign out_is_load = r_is_load;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Directed self-checking bench for alu_operand_stage. Inputs are
//            driven just after the falling edge; registered outputs are
//            sampled at the next falling edge, combinational ones #1 after
//            driving.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd, exm_rd, wb_rd, out_rd;
  logic [31:0] in_rs_data, in_rt_data, in_imm, exm_data, wb_data, A, B;
  logic        in_use_imm, in_is_load, exm_we, exm_is_load, wb_we;
  logic [5:0]  in_alufun, ALUFun;
  logic        out_valid, out_ready, out_is_load;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DW(32), .RW(5), .FW(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_alufun(in_alufun), .in_rd(in_rd), .in_is_load(in_is_load),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .exm_is_load(exm_is_load), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUFun(ALUFun), .out_rd(out_rd),
    .out_is_load(out_is_load)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_rs_data = 0;
    in_rt_data = 0; in_imm = 0; in_use_imm = 0; in_alufun = 0; in_rd = 0;
    in_is_load = 0; exm_we = 0; exm_rd = 0; exm_data = 0; exm_is_load = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [31:0] rs_d,
                       input logic [4:0] rt, input logic [31:0] rt_d,
                       input logic use_imm, input logic [31:0] imm,
                       input logic [5:0] fun, input logic [4:0] rd);
    in_valid = 1; in_rs = rs; in_rs_data = rs_d; in_rt = rt;
    in_rt_data = rt_d; in_use_imm = use_imm; in_imm = imm;
    in_alufun = fun; in_rd = rd;
  endtask

  initial begin
    idle_inputs();
    reset = 1; out_ready = 1;

    // Reset for two cycles
    @(negedge clk); @(negedge clk);
    chk("rst_valid",  {31'b0, out_valid}, 32'h0);
    chk("rst_A",      A, 32'h0);
    chk("rst_B",      B, 32'h0);
    chk("rst_fun",    {26'b0, ALUFun}, 32'h0);
    chk("rst_rd",     {27'b0, out_rd}, 32'h0);
    chk("rst_isload", {31'b0, out_is_load}, 32'h0);
    reset = 0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Logic op: A=r1, B=r2
    instr(5'd1, 32'h1, 5'd2, 32'h0, 1'b0, 32'h0, 6'b011000, 5'd7);
    @(negedge clk);
    chk("logic_valid", {31'b0, out_valid}, 32'h1);
    chk("logic_A",     A, 32'h1);
    chk("logic_B",     B, 32'h0);
    chk("logic_fun",   {26'b0, ALUFun}, 32'h18);
    chk("logic_rd",    {27'b0, out_rd}, 32'h7);

    // EX/MEM beats MEM/WB on rs; rt from register file
    instr(5'd3, 32'h1234, 5'd5, 32'h77, 1'b0, 32'h0, 6'b000001, 5'd8);
    exm_we = 1; exm_rd = 5'd3; exm_data = 32'hAAAA_0000;
    wb_we = 1;  wb_rd = 5'd3;  wb_data = 32'h5555;
    @(negedge clk);
    chk("fwd_prio_A", A, 32'hAAAA_0000);
    chk("fwd_prio_B", B, 32'h77);
    chk("fwd_valid",  {31'b0, out_valid}, 32'h1);

    // MEM/WB only, on rt
    instr(5'd9, 32'h9, 5'd3, 32'h1234, 1'b0, 32'h0, 6'b000010, 5'd8);
    exm_we = 0;
    @(negedge clk);
    chk("fwd_wb_B", B, 32'h5555);
    chk("fwd_wb_A", A, 32'h9);

    // r0 always reads zero even with matching forwarders; immediate on B
    instr(5'd0, 32'hDEAD, 5'd0, 32'h0, 1'b1, 32'hFFFF_FFF0, 6'b100000, 5'd2);
    exm_we = 1; exm_rd = 5'd0; wb_rd = 5'd0;
    @(negedge clk);
    chk("r0_A",  A, 32'h0);
    chk("imm_B", B, 32'hFFFF_FFF0);

    // Load-use on rs: stall, previous entry drains, bubble follows
    instr(5'd4, 32'h0, 5'd6, 32'h66, 1'b0, 32'h0, 6'b000011, 5'd10);
    exm_we = 1; exm_is_load = 1; exm_rd = 5'd4; wb_we = 0;
    #1 chk("lu_in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    chk("lu_bubble", {31'b0, out_valid}, 32'h0);
    // Load result now arrives on MEM/WB
    exm_we = 0; exm_is_load = 0; wb_we = 1; wb_rd = 5'd4; wb_data = 32'h4444;
    #1 chk("lu_release_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    chk("lu_A",     A, 32'h4444);
    chk("lu_valid", {31'b0, out_valid}, 32'h1);

    // Load targets rt only, but B is immediate: no stall
    instr(5'd6, 32'h60, 5'd4, 32'h0, 1'b1, 32'h1F, 6'b000100, 5'd11);
    exm_we = 1; exm_is_load = 1; exm_rd = 5'd4; wb_we = 0;
    #1 chk("imm_no_stall", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    chk("imm_ns_A", A, 32'h60);
    chk("imm_ns_B", B, 32'h1F);
    exm_we = 0; exm_is_load = 0;

    // Backpressure: 3 cycles frozen, then transfer + accept together
    out_ready = 0;
    instr(5'd8, 32'h88, 5'd0, 32'h0, 1'b0, 32'h0, 6'b001000, 5'd12);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_A",     A, 32'h60);
      chk("bp_fun",   {26'b0, ALUFun}, 32'h04);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    chk("bp_new_A",     A, 32'h88);
    chk("bp_new_valid", {31'b0, out_valid}, 32'h1);

    // Flush while FULL with a pending instruction
    instr(5'd9, 32'h99, 5'd0, 32'h0, 1'b0, 32'h0, 6'b010000, 5'd13);
    flush = 1; out_ready = 0;
    #1 chk("fl_in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    chk("fl_valid", {31'b0, out_valid}, 32'h0);
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("fl_not_captured", {31'b0, out_valid}, 32'h0);
    chk("fl_A_kept",       A, 32'h88);

    // Reset in the middle of a stall
    instr(5'd1, 32'hCAFE, 5'd0, 32'h0, 1'b0, 32'h0, 6'b111111, 5'd31);
    in_is_load = 1;
    @(negedge clk);
    chk("ms_fill_A", A, 32'hCAFE);
    chk("ms_fill_isload", {31'b0, out_is_load}, 32'h1);
    in_valid = 0;
    @(negedge clk);
    chk("ms_stall_valid", {31'b0, out_valid}, 32'h1);
    reset = 1;
    @(negedge clk);
    chk("ms_rst_valid",  {31'b0, out_valid}, 32'h0);
    chk("ms_rst_A",      A, 32'h0);
    chk("ms_rst_fun",    {26'b0, ALUFun}, 32'h0);
    chk("ms_rst_rd",     {27'b0, out_rd}, 32'h0);
    chk("ms_rst_isload", {31'b0, out_is_load}, 32'h0);
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
